// File: rtl/logic_op_pkg.sv
// Shared op codes, FSM encoding and op classification helpers for the
// bitwise logic pipeline.
package logic_op_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    BASE_AND  = 2'd0,
    BASE_OR   = 2'd1,
    BASE_XOR  = 2'd2,
    BASE_NONE = 2'd3
  } base_e;

  function automatic base_e base_of(input logic [2:0] op);
    base_e b;
    case (op)
      OP_AND, OP_NAND: b = BASE_AND;
      OP_OR,  OP_NOR:  b = BASE_OR;
      OP_XOR, OP_XNOR: b = BASE_XOR;
      default:         b = BASE_NONE;
    endcase
    return b;
  endfunction

  function automatic logic is_inv(input logic [2:0] op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

endpackage

// File: rtl/logic_op_reduce.sv
// Combinational fold of N_CH channels (plus an optional seed word) with one
// base operator; BASE_NONE yields all-zero.
module logic_op_reduce
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4
) (
  input  logic [N_CH*WIDTH-1:0] i_data,
  input  base_e                 i_base,
  input  logic [WIDTH-1:0]      i_seed,
  input  logic                  i_seed_en,
  output logic [WIDTH-1:0]      o_data
);

  function automatic logic [WIDTH-1:0] combine(input base_e b,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (b)
      BASE_AND: r = x & y;
      BASE_OR:  r = x | y;
      BASE_XOR: r = x ^ y;
      default:  r = '0;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] w_fold;

  // Channel 0 seeds the chain, so N_CH=1 passes straight through.
  always_comb begin
    w_fold = i_data[WIDTH-1:0];
    for (int k = 1; k < N_CH; k++)
      w_fold = combine(i_base, w_fold, i_data[k*WIDTH +: WIDTH]);
    if (i_seed_en)
      w_fold = combine(i_base, w_fold, i_seed);
    if (i_base == BASE_NONE)
      w_fold = '0;
  end

  assign o_data = w_fold;

endmodule

// File: rtl/logic_op_pipe.sv
// Single-stage registered bitwise logic unit with valid/ready handshake and an
// optional multi-beat accumulate mode folding a frame into one result.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            op,
  input  logic                  acc_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [CNT_W-1:0]      out_beats
);

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic             r_acc_en;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [CNT_W-1:0] r_out_beats;

  logic             w_accept;
  logic             w_in_accum;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_red;
  logic [WIDTH-1:0] w_result;
  logic [CNT_W-1:0] w_cnt_sat;
  logic [CNT_W-1:0] w_beats;
  logic             w_emit;
  logic             w_load;
  logic             w_latch;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_in_accum = (r_state == ST_ACCUM);

  // Mid-frame changes on op/acc_en are ignored: the frame uses its first-beat op.
  assign w_op = w_in_accum ? r_op : op;

  logic_op_reduce #(
    .WIDTH (WIDTH),
    .N_CH  (N_CH)
  ) u_reduce (
    .i_data    (in_data),
    .i_base    (base_of(w_op)),
    .i_seed    (r_acc),
    .i_seed_en (w_in_accum),
    .o_data    (w_red)
  );

  // Inversion happens once, on the final fold, never per beat.
  assign w_result  = is_inv(w_op) ? ~w_red : w_red;
  assign w_cnt_sat = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_beats   = w_in_accum ? w_cnt_sat : CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && acc_en && !in_last) w_state_nxt = ST_ACCUM;
      ST_ACCUM: if (w_accept && (in_last || !r_acc_en)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_emit  = 1'b0;
    w_load  = 1'b0;
    w_latch = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        w_load  = acc_en && !in_last;
        w_emit  = !(acc_en && !in_last);
        w_latch = acc_en && !in_last;
      end
      ST_ACCUM: if (w_accept) begin
        w_emit = in_last || !r_acc_en;
        w_load = !(in_last || !r_acc_en);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_op     <= OP_AND;
      r_acc_en <= 1'b0;
    end else begin
      if (w_load) begin
        r_acc <= w_red;
        r_cnt <= w_beats;
      end
      if (w_latch) begin
        r_op     <= op;
        r_acc_en <= acc_en;
      end
    end
  end

  // Overwrite on a new result even while the old one is being taken: no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_beats <= '0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_beats <= w_beats;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_beats = r_out_beats;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Randomized and directed bench for logic_op_pipe against a frame-level
// behavioural model; a CNT_W=2 copy shares the stimulus to exercise saturation.
module tb_logic_op_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  op = '0;
  logic        acc_en = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [7:0]  out_data, out_beats;
  logic        in_ready2, out_valid2;
  logic [7:0]  out_data2;
  logic [1:0]  out_beats2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(8), .N_CH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .op(op), .acc_en(acc_en), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beats(out_beats)
  );

  logic_op_pipe #(.WIDTH(8), .N_CH(4), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .op(op), .acc_en(acc_en), .in_valid(in_valid),
    .in_ready(in_ready2), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_beats(out_beats2)
  );

  // Model: the output register contents, plus the raw beats of the open frame.
  bit          exp_valid = 0;
  logic [7:0]  exp_data  = '0;
  int          exp_cnt   = 0;
  bit          in_frame  = 0;
  logic [2:0]  f_op      = '0;
  logic [31:0] f_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fold(input logic [2:0] o);
    logic [7:0] r;
    int b;
    b = (o == 0 || o == 3) ? 0 : (o == 1 || o == 4) ? 1 : (o == 2 || o == 5) ? 2 : 3;
    if (b == 3) return 8'h00;
    r = (b == 0) ? 8'hFF : 8'h00;
    foreach (f_q[i])
      for (int ch = 0; ch < 4; ch++) begin
        logic [31:0] w;
        logic [7:0]  v;
        w = f_q[i];
        v = w[ch*8 +: 8];
        if (b == 0) r = r & v;
        else if (b == 1) r = r | v;
        else r = r ^ v;
      end
    if (o >= 3) r = ~r;
    return r;
  endfunction

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic model_reset();
    exp_valid = 0; exp_data = '0; exp_cnt = 0; in_frame = 0; f_q.delete();
  endtask

  task automatic compare_outputs();
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    chk("out_data", {24'd0, out_data}, {24'd0, exp_data});
    chk("out_beats", {24'd0, out_beats}, sat(exp_cnt, 255));
    chk("c2_out_valid", {31'd0, out_valid2}, {31'd0, exp_valid});
    chk("c2_out_data", {24'd0, out_data2}, {24'd0, exp_data});
    chk("c2_out_beats", {30'd0, out_beats2}, sat(exp_cnt, 3));
  endtask

  // One cycle: check settled outputs, drive new inputs, advance the model to
  // what the next rising edge must produce.
  task automatic step(input bit v, input logic [2:0] o, input bit acc, input bit last,
                      input logic [31:0] d, input bit rdy);
    bit m_rdy;
    @(negedge clk);
    compare_outputs();
    in_valid = v; op = o; acc_en = acc; in_last = last; in_data = d; out_ready = rdy;
    #1;
    m_rdy = !exp_valid || rdy;
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
    chk("c2_in_ready", {31'd0, in_ready2}, {31'd0, m_rdy});
    if (exp_valid && rdy) exp_valid = 0;
    if (v && m_rdy) begin
      if (!in_frame) begin
        f_op = o;
        f_q.delete();
        f_q.push_back(d);
        if (acc && !last) in_frame = 1;
      end else begin
        f_q.push_back(d);
        if (last) in_frame = 0;
      end
      if (!in_frame) begin
        exp_valid = 1;
        exp_data  = fold(f_op);
        exp_cnt   = f_q.size();
      end
    end
  endtask

  task automatic lit(input string name, input bit v, input logic [7:0] d, input logic [7:0] b);
    @(posedge clk);
    #2;
    chk({name, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({name, "_data"}, {24'd0, out_data}, {24'd0, d});
    chk({name, "_beats"}, {24'd0, out_beats}, {24'd0, b});
  endtask

  task automatic async_reset();
    @(negedge clk);
    compare_outputs();
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_beats", {24'd0, out_beats}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  logic [7:0] sweep_exp [8] = '{8'h80, 8'hFF, 8'h69, 8'h7F, 8'h00, 8'h96, 8'h00, 8'h00};

  initial begin
    model_reset();
    #12;
    chk("por_out_valid", {31'd0, out_valid}, 32'd0);
    chk("por_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 0;

    // Simple OR beat
    step(1, 3'd1, 0, 0, 32'h08040201, 1);
    lit("or", 1, 8'h0F, 8'd1);

    // Operator sweep over a fixed pattern
    for (int o = 0; o < 8; o++) begin
      step(1, 3'(o), 0, 0, 32'hFFAACCF0, 1);
      lit("sweep", 1, sweep_exp[o], 8'd1);
    end
    step(0, 3'd0, 0, 0, 32'h0, 1);

    // Back-pressure then no-bubble refill
    step(1, 3'd1, 0, 0, 32'h00000011, 0);
    lit("bp1", 1, 8'h11, 8'd1);
    step(1, 3'd1, 0, 0, 32'h00000022, 0);
    lit("bp_hold", 1, 8'h11, 8'd1);
    step(1, 3'd1, 0, 0, 32'h00000022, 1);
    lit("bp2", 1, 8'h22, 8'd1);
    step(0, 3'd1, 0, 0, 32'h0, 1);
    lit("drain", 0, 8'h22, 8'd1);

    // XOR accumulation of three beats; op changes mid-frame must be ignored
    step(1, 3'd2, 1, 0, 32'h00000001, 1);
    lit("acc1", 0, 8'h22, 8'd1);
    step(1, 3'd0, 1, 0, 32'h00000002, 1);
    lit("acc2", 0, 8'h22, 8'd1);
    step(1, 3'd1, 0, 1, 32'h00000004, 1);
    lit("acc3", 1, 8'h07, 8'd3);

    // Five-beat frame: CNT_W=2 copy saturates at 3
    for (int i = 0; i < 5; i++) step(1, 3'd1, 1, i == 4, 32'h1 << i, 1);
    @(posedge clk); #2;
    chk("sat5_beats", {24'd0, out_beats}, 32'd5);
    chk("sat5_c2_beats", {30'd0, out_beats2}, 32'd3);
    chk("sat5_data", {24'd0, out_data}, 32'h1F);

    // Long frame saturates the 8-bit counter
    for (int i = 0; i < 260; i++) step(1, 3'd2, 1, i == 259, $urandom, 1);
    @(posedge clk); #2;
    chk("sat255_beats", {24'd0, out_beats}, 32'd255);

    // Reset while a result is held, then reset mid-frame; next frame starts clean
    step(1, 3'd1, 0, 0, 32'h000000F0, 0);
    async_reset();
    step(1, 3'd1, 1, 0, 32'h000000FF, 1);
    step(1, 3'd1, 1, 0, 32'h0000FF00, 1);
    async_reset();
    step(1, 3'd2, 1, 0, 32'h00000003, 1);
    step(1, 3'd2, 1, 1, 32'h00000005, 1);
    lit("clean", 1, 8'h06, 8'd2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 3, $urandom, $urandom_range(0, 9) < 7);
    step(0, 3'd0, 0, 0, 32'h0, 1);
    step(0, 3'd0, 0, 0, 32'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
